// File: rtl/summary_punch.sv
// Summary-punch controller: latches a 12-digit biquinary total and sign,
// then drives one punch magnet per column in step with the card row pulses.
module summary_punch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [71:0] digits_bq,
  input  logic        minus,
  input  logic [12:0] timing,
  output logic [11:0] punch,
  output logic        punch_sign,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, SYNC, PUNCH, FINISH} state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [12:0] t_s_q, t_d_q;
  logic [71:0] dig_q;
  logic        minus_q;
  logic [11:0] punch_q;
  logic        sign_q, busy_q, done_q, err_q;

  // Returns {legal, value}; value is only meaningful when legal.
  function automatic logic [4:0] decode_digit(input logic [5:0] code);
    logic [3:0] q;
    logic       ok;
    ok = 1'b1;
    q  = 4'd0;
    case (code[4:0])
      5'b00001: q = 4'd0;
      5'b00010: q = 4'd1;
      5'b00100: q = 4'd2;
      5'b01000: q = 4'd3;
      5'b10000: q = 4'd4;
      default:  ok = 1'b0;
    endcase
    return {ok, q + (code[5] ? 4'd5 : 4'd0)};
  endfunction

  logic [4:0]  in_dec  [12];
  logic [4:0]  lat_dec [12];
  logic [11:0] in_ok;
  logic [11:0] match;
  logic [3:0]  row_sel;

  // SYNC consumes the row-9 edge itself, so it punches row 9 directly.
  assign row_sel = (state_q == SYNC) ? 4'd9 :
                   (idx_q < 4'd10)   ? 4'd9 - idx_q : idx_q + 4'd1;

  for (genvar gi = 0; gi < 12; gi++) begin : g_digit
    assign in_dec[gi]  = decode_digit(digits_bq[6*gi +: 6]);
    assign lat_dec[gi] = decode_digit(dig_q[6*gi +: 6]);
    assign in_ok[gi]   = in_dec[gi][4];
    assign match[gi]   = lat_dec[gi][4] && (lat_dec[gi][3:0] == row_sel);
  end

  logic [12:0] rise, fall, exp_onehot;
  logic        other_rise;

  assign rise       = t_s_q & ~t_d_q;
  assign fall       = ~t_s_q & t_d_q;
  assign exp_onehot = 13'd1 << row_sel;
  assign other_rise = |(rise & ~exp_onehot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      t_s_q   <= '0;
      t_d_q   <= '0;
      dig_q   <= '0;
      minus_q <= 1'b0;
      punch_q <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      t_s_q  <= timing;
      t_d_q  <= t_s_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q  <= 1'b0;
          punch_q <= '0;
          sign_q  <= 1'b0;
          if (start) begin
            dig_q   <= digits_bq;
            minus_q <= minus;
            err_q   <= ~&in_ok;
            busy_q  <= 1'b1;
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (rise[9]) begin
            punch_q <= match;
            sign_q  <= 1'b0;
            idx_q   <= 4'd0;
            state_q <= PUNCH;
          end
        end
        PUNCH: begin
          if (other_rise) begin
            err_q   <= 1'b1;
            punch_q <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (|(rise & exp_onehot)) begin
            punch_q <= match;
            sign_q  <= (row_sel == 4'd11) && minus_q;
          end else if (|(fall & exp_onehot)) begin
            punch_q <= '0;
            sign_q  <= 1'b0;
            if (idx_q == 4'd11) state_q <= FINISH;
            else                idx_q   <= idx_q + 4'd1;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign punch      = punch_q;
  assign punch_sign = sign_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule
